// File: rtl/fifo_tx_pkg.sv
// Shared types and constants for the FIFO-fed serial transmitter.
// Define FIFO_TX_PARITY_EN to add an even-parity bit after the data bits.
package fifo_tx_pkg;

  localparam int DATA_BITS            = 8;
  localparam int FRAME_BITS_NO_PARITY = DATA_BITS + 2;
  localparam int FRAME_BITS_PARITY    = DATA_BITS + 3;

`ifdef FIFO_TX_PARITY_EN
  localparam int FRAME_BITS = FRAME_BITS_PARITY;
`else
  localparam int FRAME_BITS = FRAME_BITS_NO_PARITY;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_START,
    ST_DATA,
`ifdef FIFO_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/fifo_serial_tx_baud_tick.sv
// Bit timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last count.
// A synchronous clear restarts the count so a new bit period begins cleanly.
module baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_count;

  // NOTE: sequential state is assigned with <= so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr || r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign tick = (r_count == LAST);

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops bytes from the FIFO read port and sends them as start/8 data/stop frames.
// Define FIFO_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module fifo_serial_tx
  import fifo_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_en,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 fifo_rd_en,
  output logic                 tx,
  output logic                 busy,
  output logic [7:0]           frame_count
);

  localparam int               IDX_W    = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  tx_state_e            r_state;
  tx_state_e            w_state_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [IDX_W-1:0]     r_bit_idx;
  logic                 r_tx;
  logic                 w_tx_next;
  logic [7:0]           r_frame_count;
  logic                 w_tick;
  logic                 w_timer_clr;
`ifdef FIFO_TX_PARITY_EN
  logic                 r_parity;
`endif

  // Restarting the timer in LOAD makes the start bit exactly one bit period.
  assign w_timer_clr = (r_state == ST_LOAD);

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_timer_clr),
    .tick (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_tx    <= w_tx_next;
    end
  end

  // tx is computed for the next state so the registered line changes on the transition edge.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    w_state_next = r_state;
    w_tx_next    = r_tx;
    case (r_state)
      ST_IDLE: begin
        w_tx_next = 1'b1;
        if (tx_en && !fifo_empty) w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        w_tx_next    = 1'b1;
        w_state_next = ST_LOAD;
      end
      ST_LOAD: begin
        w_tx_next    = 1'b0;
        w_state_next = ST_START;
      end
      ST_START: begin
        if (w_tick) begin
          w_tx_next    = r_shift[0];
          w_state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_bit_idx == LAST_IDX) begin
`ifdef FIFO_TX_PARITY_EN
            w_tx_next    = r_parity;
            w_state_next = ST_PARITY;
`else
            w_tx_next    = 1'b1;
            w_state_next = ST_STOP;
`endif
          end else begin
            w_tx_next = r_shift[1];
          end
        end
      end
`ifdef FIFO_TX_PARITY_EN
      ST_PARITY: begin
        if (w_tick) begin
          w_tx_next    = 1'b1;
          w_state_next = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (w_tick) begin
          w_tx_next    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_tx_next    = 1'b1;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift       <= '0;
      r_bit_idx     <= '0;
      r_frame_count <= '0;
`ifdef FIFO_TX_PARITY_EN
      r_parity      <= 1'b0;
`endif
    end else begin
      if (r_state == ST_LOAD) begin
        r_shift   <= fifo_data;
        r_bit_idx <= '0;
`ifdef FIFO_TX_PARITY_EN
        r_parity  <= ^fifo_data;
`endif
      end else if (r_state == ST_DATA && w_tick) begin
        r_shift   <= r_shift >> 1;
        r_bit_idx <= r_bit_idx + 1'b1;
      end
      if (r_state == ST_STOP && w_tick) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  assign fifo_rd_en  = (r_state == ST_FETCH);
  assign busy        = (r_state != ST_IDLE);
  assign tx          = r_tx;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: a queue-based FIFO feeds the DUT and a frame decoder checks the line.
// Works with or without FIFO_TX_PARITY_EN defined.
module tb_fifo_serial_tx;

  localparam int CPB = 4;
`ifdef FIFO_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FLEN = NBITS * CPB;

  logic       clk        = 1'b0;
  logic       rst        = 1'b1;
  logic       tx_en      = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data  = '0;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic [7:0] frame_count;

  // Second instance at two clocks per bit, fed by a one-byte source.
  logic       want2      = 1'b0;
  logic       fifo_empty2;
  logic [7:0] fifo_data2 = 8'h3C;
  logic       rd2, tx2, busy2;
  logic [7:0] fc2;

  assign fifo_empty2 = ~want2;

  always #5 clk = ~clk;

  fifo_serial_tx #(.CLKS_PER_BIT(CPB)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .tx_en       (tx_en),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_rd_en  (fifo_rd_en),
    .tx          (tx),
    .busy        (busy),
    .frame_count (frame_count)
  );

  fifo_serial_tx #(.CLKS_PER_BIT(2)) u_dut_fast (
    .clk         (clk),
    .rst         (rst),
    .tx_en       (tx_en),
    .fifo_empty  (fifo_empty2),
    .fifo_data   (fifo_data2),
    .fifo_rd_en  (rd2),
    .tx          (tx2),
    .busy        (busy2),
    .frame_count (fc2)
  );

  int         n_vec     = 0;
  int         n_bad     = 0;
  int         exp_count = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] push_q[$];
  logic       tx_log[$];
  logic       rd_log[$];
  logic       busy_log[$];

  // FIFO: registered data_out updates on the pop edge; writes land on the next edge.
  always @(posedge clk) begin
    if (fifo_rd_en === 1'b1 && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
    while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
    fifo_empty <= (fifo_q.size() == 0);
  end

  always @(negedge clk) begin
    tx_log.push_back(tx);
    rd_log.push_back(fifo_rd_en);
    busy_log.push_back(busy);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected line levels, bit 0 first: start, data LSB first, [even parity], stop.
  function automatic logic [10:0] frame_word(input logic [7:0] d);
    logic [10:0] w;
`ifdef FIFO_TX_PARITY_EN
    w = {1'b1, ^d, d, 1'b0};
`else
    w = {2'b01, d, 1'b0};
`endif
    return w;
  endfunction

  task automatic push_bytes(input logic [7:0] b[$]);
    foreach (b[k]) push_q.push_back(b[k]);
  endtask

  task automatic run_until_quiet(input int max_cyc);
    int quiet = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (busy !== 1'b0 || fifo_empty !== 1'b1 || push_q.size() > 0) quiet = 0;
      else quiet++;
      if (quiet == 4) return;
    end
    check("quiet_timeout", quiet, 4);
  endtask

  task automatic wait_tx_low(input int max_cyc);
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (tx === 1'b0) return;
    end
    check("tx_low_timeout", tx, 0);
  endtask

  task automatic wait_not_busy(input int max_cyc);
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (busy === 1'b0) return;
    end
    check("idle_timeout", busy, 0);
  endtask

  // Decode every frame logged since 'from' and compare against the expected byte list.
  task automatic check_frames(input string tag, input int from, input logic [7:0] exp_q[$],
                              input bit b2b);
    int          i        = from;
    int          last     = tx_log.size();
    int          nf       = 0;
    int          prev_end = -1;
    int          n_rd     = 0;
    int          n_busy   = 0;
    logic [10:0] obs;
    bit          stable;
    for (int j = from; j < last; j++) begin
      n_rd   += int'(rd_log[j] === 1'b1);
      n_busy += int'(busy_log[j] === 1'b1);
    end
    while (i < last) begin
      if (tx_log[i] === 1'b0) begin
        if (i + FLEN > last) break;
        obs    = '0;
        stable = 1'b1;
        for (int k = 0; k < NBITS; k++) begin
          obs[k] = tx_log[i + k*CPB + CPB/2];
          for (int c = 0; c < CPB; c++)
            if (tx_log[i + k*CPB + c] !== obs[k]) stable = 1'b0;
        end
        if (nf < exp_q.size()) check({tag, "_frame"}, obs, frame_word(exp_q[nf]));
        check({tag, "_bit_stable"}, stable, 1);
        if (i >= 2) check({tag, "_rd_en_at_E"}, rd_log[i-2], 1);
        if (b2b && prev_end >= 0) check({tag, "_gap"}, i - prev_end, 3);
        prev_end = i + FLEN;
        nf++;
        i = prev_end;
      end else begin
        i++;
      end
    end
    check({tag, "_nframes"}, nf, exp_q.size());
    check({tag, "_rd_pulses"}, n_rd, exp_q.size());
    check({tag, "_busy_cycles"}, n_busy, exp_q.size() * (FLEN + 2));
  endtask

  initial begin
    logic [7:0] bytes[$];
    logic       q2[$];
    logic [10:0] w2;
    int         base;
    int         cnt;
    int         n;
    bit         found;

    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_count", frame_count, 0);
    rst = 1'b0;

    // Single byte 0xA5.
    tx_en = 1'b1;
    base  = tx_log.size();
    bytes = '{8'hA5};
    push_bytes(bytes);
    run_until_quiet(300);
    check_frames("a5", base, bytes, 1'b0);
    exp_count++;
    check("a5_count", frame_count, exp_count % 256);

    // Four bytes queued while disabled, then released back to back.
    tx_en = 1'b0;
    base  = tx_log.size();
    bytes = '{8'h01, 8'h80, 8'hFF, 8'h00};
    push_bytes(bytes);
    repeat (20) @(negedge clk);
    cnt = 0;
    for (int j = base; j < tx_log.size(); j++) cnt += int'(rd_log[j] === 1'b1);
    check("hold_no_pop", cnt, 0);
    check("hold_idle", busy, 0);
    tx_en = 1'b1;
    run_until_quiet(600);
    check_frames("burst4", base, bytes, 1'b1);
    exp_count += 4;
    check("burst4_count", frame_count, exp_count % 256);

    // Random bursts.
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 8);
      bytes.delete();
      for (int k = 0; k < n; k++) bytes.push_back(8'($urandom));
      base = tx_log.size();
      push_bytes(bytes);
      run_until_quiet(800);
      check_frames("rand", base, bytes, 1'b1);
      exp_count += n;
      check("rand_count", frame_count, exp_count % 256);
    end

    // tx_en dropped during DATA of a two-byte burst.
    base  = tx_log.size();
    bytes = '{8'($urandom), 8'($urandom)};
    push_bytes(bytes);
    wait_tx_low(100);
    repeat (CPB * 3) @(negedge clk);
    tx_en = 1'b0;
    wait_not_busy(200);
    repeat (30) @(negedge clk);
    cnt = 0;
    for (int j = base; j < tx_log.size(); j++) cnt += int'(rd_log[j] === 1'b1);
    check("drop_one_pop", cnt, 1);
    check("drop_fifo_level", fifo_q.size(), 1);
    check("drop_count", frame_count, (exp_count + 1) % 256);
    tx_en = 1'b1;
    run_until_quiet(300);
    check_frames("drop", base, bytes, 1'b0);
    exp_count += 2;
    check("drop_count_after", frame_count, exp_count % 256);

    // Reset during data bit 3.
    bytes = '{8'($urandom)};
    push_bytes(bytes);
    wait_tx_low(100);
    repeat (CPB * 4 + 1) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_rst_tx", tx, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_count", frame_count, 0);
    @(negedge clk);
    rst       = 1'b0;
    exp_count = 0;
    base      = tx_log.size();
    repeat (30) @(negedge clk);
    cnt = 0;
    for (int j = base; j < tx_log.size(); j++) cnt += int'(tx_log[j] !== 1'b1);
    check("post_rst_line_idle", cnt, 0);
    cnt = 0;
    for (int j = base; j < tx_log.size(); j++) cnt += int'(rd_log[j] === 1'b1);
    check("post_rst_no_pop", cnt, 0);
    base  = tx_log.size();
    bytes = '{8'($urandom)};
    push_bytes(bytes);
    run_until_quiet(300);
    check_frames("post_rst", base, bytes, 1'b0);
    exp_count++;
    check("post_rst_count", frame_count, exp_count % 256);

    // Two clocks per bit: frame lasts 2*NBITS cycles.
    want2 = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rd2 === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    want2 = 1'b0;
    check("fast_pop", found, 1);
    q2.delete();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (busy2 !== 1'b1) break;
      q2.push_back(tx2);
    end
    check("fast_busy_len", q2.size(), 1 + NBITS * 2);
    w2 = '0;
    for (int k = 0; k < NBITS; k++)
      if (1 + 2*k < q2.size()) w2[k] = q2[1 + 2*k];
    check("fast_frame", w2, frame_word(fifo_data2));
    check("fast_count", fc2, 1);

    // 256 frames from reset: the counter wraps back to 0.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    exp_count = 0;
    check("wrap_start", frame_count, 0);
    for (int chunk = 0; chunk < 32; chunk++) begin
      bytes.delete();
      for (int k = 0; k < 8; k++) bytes.push_back(8'($urandom));
      base = tx_log.size();
      push_bytes(bytes);
      run_until_quiet(800);
      check_frames("wrap", base, bytes, 1'b1);
      exp_count += 8;
      check("wrap_chunk_count", frame_count, exp_count % 256);
    end
    check("wrap_final", frame_count, exp_count % 256);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_serial_tx.md
# fifo_serial_tx

Drains bytes from the 8-deep byte FIFO through its read port (`rd_en`/`empty`/`data_out`) and transmits each one as an asynchronous serial frame: start bit, 8 data bits LSB first, optional parity, stop bit. It sits on the read side of the FIFO and is the consumer for the FIFO's write-side producer. It also keeps a wrapping count of completed frames for status.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range 2..65535.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `tx_en`  in  1  allows new frames to start; does not abort a frame in progress.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_data`  in  8  FIFO registered `data_out`.
- `fifo_rd_en`  out  1  pop request to the FIFO; one-cycle pulse.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high in every state except IDLE.
- `frame_count`  out  8  completed frames; wraps 255 -> 0.

## Operation
- States: IDLE, FETCH, LOAD, START, DATA, PARITY (only with the macro), STOP.
- IDLE -> FETCH on an edge where `tx_en`=1 and `fifo_empty`=0; otherwise stay in IDLE.
- FETCH: `fifo_rd_en`=1 for exactly this one cycle. It is a Moore output and is never asserted in any other state. FETCH -> LOAD unconditionally.
- LOAD: `fifo_data` is valid in this cycle because the FIFO updates it on the FETCH edge. Capture it into the shift register and clear the bit index. LOAD -> START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then -> DATA.
- DATA: `tx` = shift register bit 0; shift right on each bit boundary. After 8 bits, go to PARITY, or to STOP when the macro is absent.
- PARITY: `tx` = XOR of the 8 captured bits (even parity) for CLKS_PER_BIT cycles, then -> STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles, then -> IDLE. `frame_count` increments on the same edge.
- `tx` is registered, so it has no glitches.
- Bit timer:
  - Counts 0..CLKS_PER_BIT-1, sized at $clog2(CLKS_PER_BIT) bits.
  - Reloads to 0 on entry to START.
  - A bit boundary is the edge where the count equals CLKS_PER_BIT-1.
- `tx_en` falling mid-frame: the frame completes normally, and IDLE then holds.
- `fifo_empty` is sampled only in IDLE. Emptiness during a frame has no effect.

## Timing
- Reset values: `tx`=1, `fifo_rd_en`=0, `busy`=0, `frame_count`=0, state IDLE, timer 0, shift register 0.
- Call the edge where IDLE samples `fifo_empty`=0 edge E. Then:
  - `fifo_rd_en` is high from E to E+1.
  - The byte is captured at E+2.
  - `tx` falls at E+2.
- Frame length is exactly 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with parity.
- Back-to-back frames with a non-empty FIFO: `tx` stays high for 3 cycles after the stop bit ends (IDLE, FETCH, LOAD) before the next start bit.
- `busy` rises at E and falls on the edge that returns to IDLE.
- Reset mid-frame:
  - `tx` goes to 1 immediately, without waiting for a clock edge.
  - The frame is abandoned, and a byte already popped is lost.
  - `frame_count` is cleared.
- The block never pops while `fifo_empty`=1, so no underflow is possible from this side.

## Configuration
- `FIFO_TX_PARITY_EN` defined: the PARITY state is compiled in; frames are 11 bits with even parity after bit 7.
- Not defined: no PARITY state or parity logic; frames are 10 bits and DATA goes directly to STOP.

## Structure
- Package `fifo_tx_pkg`:
  - state enum;
  - `DATA_BITS`=8;
  - frame-length constants for both configurations.
- One sub-module, `baud_tick`: holds the bit timer. It takes `clk`, `rst`, and a synchronous clear, and outputs a one-cycle `tick` at each bit boundary.

## Test plan
All scenarios use CLKS_PER_BIT=4 unless stated.
- Reset, then one write of 0xA5 to the FIFO: exactly one `fifo_rd_en` pulse; `tx` pattern per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1; `frame_count`=1; `busy` high for 40 cycles plus the FETCH and LOAD cycles.
- Four bytes 0x01, 0x80, 0xFF, 0x00 queued before `tx_en` rises: four frames in order; each stop bit is followed by exactly 3 high cycles before the next start bit; `frame_count`=4; exactly 4 `fifo_rd_en` pulses.
- With `FIFO_TX_PARITY_EN`, send 0x07 then 0xA5: parity bits 1 then 0; each frame lasts 44 cycles.
- `tx_en` dropped during DATA of a 2-byte burst: the first frame completes; no second `fifo_rd_en` until `tx_en` returns; the FIFO counter stays at 1.
- `rst` pulsed during bit 3 of a frame: `tx`=1 and `busy`=0 asynchronously; `frame_count`=0; nothing is transmitted until the FIFO is non-empty again.
- 256 single-byte frames: `frame_count` wraps to 0; CLKS_PER_BIT=2 frame length is 20 cycles.
